// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier:
// FSM state encoding, Booth digit encoding and sizing functions.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 32'sd1) / d;
  endfunction

  // One digit per bit pair of the 2-bit-extended multiplier.
  function automatic int ndig(input int width);
    return width / 32'sd2 + 32'sd1;
  endfunction

  // Recode {b[2i+1], b[2i], b[2i-1]} into a signed digit in -2..+2.
  function automatic digit_e booth_recode(input logic [2:0] bits);
    digit_e d;
    case (bits)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_ppgen.sv
// Combinational radix-4 Booth partial-product generator: one digit times the
// sign-extended multiplicand, shifted to its slot within the current group.
module booth_r4_ppgen import booth_pkg::*; #(
  parameter int PW    = 64,
  parameter int SHIFT = 0
) (
  input  logic [2:0]    b_bits,
  input  logic [PW-1:0] mcand,
  input  logic          en,
  output logic [PW-1:0] pp
);

  localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

  digit_e        digit_s;
  logic [PW-1:0] mult_s;

  // Select +-1x / +-2x of the multiplicand, then place it in its slot.
  always_comb begin
    digit_s = booth_recode(b_bits);
    mult_s  = {PW{1'b0}};
    case (digit_s)
      POS1:    mult_s = mcand;
      POS2:    mult_s = mcand << 1;
      NEG1:    mult_s = ~mcand + ONE;
      NEG2:    mult_s = ~(mcand << 1) + ONE;
      default: mult_s = {PW{1'b0}};
    endcase
    if (en) begin
      pp = mult_s << SHIFT;
    end else begin
      pp = {PW{1'b0}};
    end
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier retiring DPC digits per clock.
// Optional early termination when the remaining digits are all zero: BOOTH_EARLY_TERM_EN.
module booth_mul_iter import booth_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             a_signed,
  input  logic             b_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] PROD_MSB,
  output logic [WIDTH-1:0] PROD_LSB
);

  localparam int NDIG = ndig(WIDTH);
  localparam int PW   = 2 * WIDTH;
  localparam int MW   = WIDTH + 3;
  localparam int SH   = 2 * DPC;
  localparam int IW   = $clog2(2 * NDIG + 1);
  localparam logic [IW-1:0] DPC_INC  = IW'(DPC);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - DPC);

  state_e        state_r, state_nxt_s;
  logic [IW-1:0] idx_r;
  logic [PW-1:0] mcand_r, acc_r, prod_r, sum_s;
  logic [MW-1:0] mplier_r, mplier_nxt_s;
  logic [PW-1:0] pp_s [DPC];
  logic [DPC-1:0] slot_en_s;
  logic          last_s, finish_s;
  logic          out_valid_r, in_ready_r;

  // mplier_r bit 0 is the overlap bit b[2i-1] of the current group.
  for (genvar k = 0; k < DPC; k++) begin : g_pp
    assign slot_en_s[k] = (int'(idx_r) + k) < NDIG;
    booth_r4_ppgen #(.PW(PW), .SHIFT(2 * k)) u_ppgen (
      .b_bits (mplier_r[2*k+2 -: 3]),
      .mcand  (mcand_r),
      .en     (slot_en_s[k]),
      .pp     (pp_s[k])
    );
  end

  assign mplier_nxt_s = {{SH{mplier_r[MW-1]}}, mplier_r[MW-1:SH]};
  assign last_s       = (idx_r >= LAST_IDX);

`ifdef BOOTH_EARLY_TERM_EN
  // Uniform remaining bits (overlap included) recode to all-zero digits.
  assign finish_s = last_s || (mplier_nxt_s == {MW{1'b0}}) || (mplier_nxt_s == {MW{1'b1}});
`else
  assign finish_s = last_s;
`endif

  // Accumulator plus this group's partial products.
  always_comb begin
    sum_s = acc_r;
    for (int j = 0; j < DPC; j++) begin
      sum_s = sum_s + pp_s[j];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (finish_s) state_nxt_s = DONE;
        else          state_nxt_s = BUSY;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
      in_ready_r  <= (state_nxt_s == IDLE);
    end
  end

  // Operand capture, per-group accumulation and product write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r    <= {IW{1'b0}};
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {MW{1'b0}};
      acc_r    <= {PW{1'b0}};
      prod_r   <= {PW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r  <= {{(PW-WIDTH){a_signed & A[WIDTH-1]}}, A};
            mplier_r <= {{2{b_signed & B[WIDTH-1]}}, B, 1'b0};
            acc_r    <= {PW{1'b0}};
            idx_r    <= {IW{1'b0}};
          end
        end
        BUSY: begin
          acc_r    <= sum_s;
          idx_r    <= idx_r + DPC_INC;
          mcand_r  <= mcand_r << SH;
          mplier_r <= mplier_nxt_s;
          if (finish_s) prod_r <= sum_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign PROD_MSB  = prod_r[PW-1:WIDTH];
  assign PROD_LSB  = prod_r[WIDTH-1:0];

endmodule

// File: tb/tb_booth_mul_iter.sv
// Self-checking bench for booth_mul_iter: arithmetic reference model with a
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_booth_mul_iter;

  localparam int WIDTH = 32;
  localparam int DPC   = 1;
  localparam int NDIG  = WIDTH / 2 + 1;
  localparam int C     = (NDIG + DPC - 1) / DPC;
`ifdef BOOTH_EARLY_TERM_EN
  localparam int LAT_15X3 = 3;
`else
  localparam int LAT_15X3 = 18;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, a_signed, b_signed, out_valid, out_ready;
  logic [31:0] A, B, PROD_MSB, PROD_LSB;
  int          checks = 0;
  int          errors = 0;
  bit          run_chk = 1'b0;

  always #5 clk = ~clk;

  booth_mul_iter #(.WIDTH(WIDTH), .DPC(DPC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .PROD_MSB(PROD_MSB), .PROD_LSB(PROD_LSB)
  );

  // Reference product: extend each operand per its signedness, multiply mod 2^64.
  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic as, input logic bs);
    longint av, bv;
    av = as ? longint'($signed(a)) : longint'({32'd0, a});
    bv = bs ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(av * bv);
  endfunction

  // Compute groups until finish: all C, or the first group after which the
  // unconsumed extended bits plus the overlap bit are uniform.
  function automatic int exp_groups(input logic [31:0] b, input logic bs);
`ifdef BOOTH_EARLY_TERM_EN
    logic [34:0] bo;
    logic        all0, all1;
    bo = {{2{bs & b[31]}}, b, 1'b0};
    for (int g = 1; g < C; g++) begin
      all0 = 1'b1;
      all1 = 1'b1;
      for (int j = 2 * g * DPC; j < 35; j++) begin
        if (bo[j]) all0 = 1'b0;
        else       all1 = 1'b0;
      end
      if (all0 || all1) return g;
    end
    return C;
`else
    return C;
`endif
  endfunction

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of the handshake: 0 idle, 1 computing, 2 holding result.
  int          m_state, m_cnt, m_lat;
  logic [63:0] m_exp, m_prod;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_prod  <= 64'd0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          m_exp   <= model_prod(A, B, a_signed, b_signed);
          m_lat   <= exp_groups(B, b_signed);
          m_cnt   <= 0;
          m_state <= 1;
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_lat) begin
            m_state <= 2;
            m_prod  <= m_exp;
          end
        end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (run_chk && !rst) begin
      chk_int("out_valid", int'(out_valid), int'(m_state == 2));
      chk_int("in_ready", int'(in_ready), int'(m_state == 0));
      if (m_state == 2) chk64("prod", {PROD_MSB, PROD_LSB}, m_prod);
    end
  end

  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic as, input logic bs,
                     input int hold, input bit use_lit, input logic [63:0] lit, input int lat_lit);
    int n;
    bit got;
    @(negedge clk);
    A = a; B = b; a_signed = as; b_signed = bs; in_valid = 1'b1;
    out_ready = 1'($urandom_range(1));
    n = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      A = $urandom; B = $urandom;
      a_signed = 1'($urandom_range(1)); b_signed = 1'($urandom_range(1));
      if (out_valid) begin
        got = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
      end else begin
        in_valid = 1'($urandom_range(1));
        out_ready = 1'($urandom_range(1));
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL timeout waiting for out_valid after %0d cycles", n);
      return;
    end
    if (lat_lit > 0) chk_int("latency", n, lat_lit);
    if (use_lit) begin
      chk64("lit_prod", {PROD_MSB, PROD_LSB}, lit);
      chk64("model_pin", model_prod(a, b, as, bs), lit);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_int("in_ready_after_release", int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = 32'd0; B = 32'd0; a_signed = 1'b0; b_signed = 1'b0;
    #1;
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_in_ready", int'(in_ready), 1);
    chk64("rst_prod", {PROD_MSB, PROD_LSB}, 64'd0);
    chk_int("model_pin_lat", exp_groups(32'd3, 1'b0) + 1, LAT_15X3);
    #22 rst = 1'b0;
    run_chk = 1'b1;

    txn(32'd15, 32'd3, 1'b0, 1'b0, 0, 1'b1, 64'h00000000_0000002D, LAT_15X3);
    txn(32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1, 1'b1, 64'h00000001_FFFFFFFE, 0);
    txn(-32'sd10, 32'd20, 1'b1, 1'b1, 0, 1'b1, 64'hFFFFFFFF_FFFFFF38, 0);
    txn(32'h80000000, 32'h80000000, 1'b1, 1'b1, 2, 1'b1, 64'h40000000_00000000, 0);
    txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 5, 1'b1, 64'hFFFFFFFF_00000001, C + 1);
    txn(32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 0, 1'b1, 64'hC0000000_80000000, 0);
    txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 1'b1, 64'hFFFFFFFE_00000001, 0);

    // Reset in the middle of a computation.
    @(negedge clk);
    A = 32'd15; B = 32'd3; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_int("midrst_out_valid", int'(out_valid), 0);
    chk64("midrst_prod", {PROD_MSB, PROD_LSB}, 64'd0);
    chk_int("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    txn(32'd15, 32'd3, 1'b0, 1'b0, 0, 1'b1, 64'd45, LAT_15X3);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (t % 4 == 1) rb = rb >> $urandom_range(31);
      if (t % 4 == 2) rb = ~(rb >> $urandom_range(31));
      txn(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(4), 1'b0, 64'd0, 0);
    end

    @(negedge clk);
    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
